fa_vec_driver_checker: RTL
==========================

Name: fa_vec_driver_checker

Overview:
- Synthesizable driver/checker for the far side of the full-adder interface.
- Drives operands a, b and c (carry-in) onto the interface.
- Samples s and cy after a programmable settle time and compares them against the full-adder truth table.
- Counts mismatches and reports pass/fail.
- Replaces hand-timed initial-block stimulus with a clocked, repeatable sequencer for on-chip or emulation self-test of any full-adder instance.

Parameters:
- SETTLE_CYCLES, 4, clock cycles each vector is held before sampling (legal range 1..15).
- LOOPS, 1, number of complete passes through the 8-vector set (legal range 1..15).
- ERR_W, 4, width of the error counter; the counter saturates at 2^ERR_W-1.

Ports:
- clk  input  1  single system clock; all logic is rising-edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request to begin a run; sampled only in IDLE.
- a  output  1  operand A driven to the adder.
- b  output  1  operand B driven to the adder.
- c  output  1  carry-in driven to the adder.
- s  input  1  sum returned by the adder.
- cy  input  1  carry-out returned by the adder.
- busy  output  1  high from the cycle after start until the run finishes.
- done  output  1  high in DONE; held until the next accepted start or reset.
- pass  output  1  valid while done=1; 1 means err_count==0.
- err_count  output  ERR_W  saturating mismatch count for the current run.
- vec_idx  output  3  index of the vector currently driven.
- mismatch  output  1  one-cycle pulse in a CHECK cycle whose compare fails.

Behaviour:
- Reset (rst=1 at clk edge):
  - state goes to IDLE.
  - a, b, c, busy, done, pass, mismatch, vec_idx, err_count and the loop counter all go to 0.
  - Reset has priority over every other event, including mid-run: the run is abandoned and no done is produced.
- Vector encoding: {a,b,c} = vec_idx (a is the MSB). Vectors run in order 0..7.
- Expected results:
  - exp_s = a^b^c.
  - exp_cy = (a&b)|(a&c)|(b&c).
- All outputs are registered. a, b and c change only on the transition into SETTLE.
- FSM states: IDLE, SETTLE, CHECK, DONE.
  - IDLE:
    - start=1 → drive vector 0, clear err_count and pass, set busy=1, done=0.
    - Load settle counter = SETTLE_CYCLES-1, loop counter = 0, go to SETTLE.
    - start=0 → stay.
  - SETTLE:
    - Settle counter decrements each cycle.
    - At 0 → CHECK.
    - The state occupies exactly SETTLE_CYCLES cycles.
  - CHECK (1 cycle):
    - Compare registered-input s and cy against the expected values for the current vector.
    - On mismatch, pulse mismatch=1 and increment err_count. At all-ones, err_count holds.
    - Next vector:
      - vec_idx<7 → vec_idx+1, drive next vector, go to SETTLE.
      - vec_idx==7 and loop<LOOPS-1 → vec_idx=0, loop+1, go to SETTLE.
      - Otherwise → DONE.
  - DONE:
    - busy=0, done=1, pass=(err_count==0).
    - a, b, c hold the last vector.
    - start=1 → behaves exactly as start in IDLE.
- Timing:
  - Cycles per vector = SETTLE_CYCLES+1.
  - Run length from the start edge to done=1 = LOOPS*8*(SETTLE_CYCLES+1)+1 cycles.
- Start while busy (SETTLE or CHECK) is ignored; there is no restart and no queuing.
- s and cy are sampled only in CHECK. Glitches during SETTLE have no effect.
- mismatch is 0 in every state other than CHECK.

Test Plan:
1. Correct adder, defaults, start pulse at cycle 0 → vec_idx steps 0..7 every 5 cycles; done=1 at cycle 41; pass=1; err_count=0; mismatch never asserts.
2. Adder with s stuck at 0 → mismatch pulses on vectors 1, 2, 4 and 7; err_count=4; pass=0.
3. Adder with cy inverted, LOOPS=3 → 24 raw mismatches; err_count saturates at 15 and holds; pass=0; done at cycle 3*8*5+1=121.
4. rst asserted during SETTLE of vector 3 → next cycle state=IDLE, a=b=c=0, busy=0, err_count=0, done=0; a subsequent start runs cleanly to pass=1.
5. start re-pulsed while busy at vector 5 → ignored; run completes at its original cycle. start pulsed while done=1 → new run begins, done drops, err_count clears.
6. SETTLE_CYCLES=1 with an adder whose outputs have 2 cycles of registered latency → every vector whose expected value differs from the previous vector's is flagged. SETTLE_CYCLES=3 with the same adder → pass=1.

Source files
------------

// File: rtl/fa_vec_if.sv
// rtl/fa_vec_if.sv - operand/result bundle between a full-adder and its driver/checker
interface fa_vec_if;
    logic a;
    logic b;
    logic c;
    logic s;
    logic cy;

    modport master (output a, output b, output c, input s, input cy);
    modport slave  (input a, input b, input c, output s, output cy);
endinterface

// File: rtl/fa_vec_driver_checker.sv
// rtl/fa_vec_driver_checker.sv - clocked full-adder exerciser: walks all 8 operand
// combinations, samples the adder after a settle time and counts wrong answers.
module fa_vec_driver_checker #(
    parameter int SETTLE_CYCLES = 4,
    parameter int LOOPS         = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    fa_vec_if.master         bus,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       vec_idx,
    output logic             mismatch
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       LOOP_LAST   = 4'(LOOPS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    state_t           state_q, state_d;
    logic [3:0]       settle_cnt_q, settle_cnt_d;
    logic [3:0]       loop_q, loop_d;
    logic [2:0]       vec_idx_q, vec_idx_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             mismatch_q, mismatch_d;

    logic exp_s;
    logic exp_cy;
    logic result_bad;
    logic start_run;

    assign exp_s      = ^vec_idx_q;
    assign exp_cy     = (vec_idx_q[2] & vec_idx_q[1]) | (vec_idx_q[2] & vec_idx_q[0])
                      | (vec_idx_q[1] & vec_idx_q[0]);
    assign result_bad = (bus.s != exp_s) || (bus.cy != exp_cy);
    assign start_run  = start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        loop_d       = loop_q;
        vec_idx_d    = vec_idx_q;
        err_count_d  = err_count_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        mismatch_d   = 1'b0;

        if (start_run) begin
            state_d      = SETTLE;
            settle_cnt_d = SETTLE_LOAD;
            loop_d       = 4'd0;
            vec_idx_d    = 3'd0;
            err_count_d  = '0;
            busy_d       = 1'b1;
            done_d       = 1'b0;
            pass_d       = 1'b0;
        end else begin
            case (state_q)
                SETTLE: begin
                    if (settle_cnt_q == 4'd0) begin
                        // The adder answer is captured on the edge into CHECK, so the
                        // verdict flops are what the CHECK cycle presents.
                        state_d    = CHECK;
                        mismatch_d = result_bad;
                        if (result_bad && (err_count_q != ERR_MAX)) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                    end else begin
                        settle_cnt_d = settle_cnt_q - 4'd1;
                    end
                end
                CHECK: begin
                    if (vec_idx_q != 3'd7) begin
                        state_d      = SETTLE;
                        settle_cnt_d = SETTLE_LOAD;
                        vec_idx_d    = vec_idx_q + 3'd1;
                    end else if (loop_q < LOOP_LAST) begin
                        state_d      = SETTLE;
                        settle_cnt_d = SETTLE_LOAD;
                        vec_idx_d    = 3'd0;
                        loop_d       = loop_q + 4'd1;
                    end else begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_count_q == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            settle_cnt_q <= 4'd0;
            loop_q       <= 4'd0;
            vec_idx_q    <= 3'd0;
            err_count_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            mismatch_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            loop_q       <= loop_d;
            vec_idx_q    <= vec_idx_d;
            err_count_q  <= err_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            mismatch_q   <= mismatch_d;
        end
    end

    // Operands are the vector index itself, so they move only when vec_idx does.
    assign bus.a     = vec_idx_q[2];
    assign bus.b     = vec_idx_q[1];
    assign bus.c     = vec_idx_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign vec_idx   = vec_idx_q;
    assign mismatch  = mismatch_q;

endmodule
